// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   state_t  : control FSM encoding (IDLE, RUN, DONE)
//   MODE_ADD : value of 'sub' selecting a + b
//   MODE_SUB : value of 'sub' selecting a - b
// ---------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : addsub_pkg

// File: rtl/fadder.sv
// ---------------------------------------------------------------------------
// fadder
// Single-bit combinational full adder cell.
//   x, y  : operand bits
//   z     : carry in
//   sum   : x ^ y ^ z
//   carry : majority(x, y, z)
// ---------------------------------------------------------------------------
module fadder (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y,
  input  logic z
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule : fadder

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial adder/subtractor. One full-adder cell plus a carry flip-flop
// processes two WIDTH-bit operands LSB first, one bit per clock.
//
// Parameters
//   WIDTH  : operand/result width, 2..64
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : operation request, accepted only while ready is high
//   sub    : 0 = a + b, 1 = a - b (sampled with start)
//   a, b   : operands (sampled with start)
//   ready  : high in IDLE
//   busy   : high in RUN
//   done   : one-cycle pulse, result/cout/ovf valid
//   result : two's complement sum/difference, modulo 2^WIDTH
//   cout   : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : signed overflow
// ---------------------------------------------------------------------------
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic bit_sum;
  logic bit_carry;

  // The only arithmetic in the design: one full adder fed by the LSBs of
  // both shift registers and the stored carry.
  fadder u_fadder (
    .sum   (bit_sum),
    .carry (bit_carry),
    .x     (sa[0]),
    .y     (sb[0]),
    .z     (carry_q)
  );

  // Control FSM and datapath in one block. Subtraction is a + ~b + 1: the
  // inverted B goes into SB and the +1 enters as the initial carry.
  // On the last bit, carry_q still holds the carry into the MSB while
  // bit_carry is the carry out of it; their XOR is the signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= (sub == MODE_SUB) ? ~b : b;
            carry_q <= (sub == MODE_SUB);
            cnt     <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          result  <= {bit_sum, result[WIDTH-1:1]};
          sa      <= {1'b0, sa[WIDTH-1:1]};
          sb      <= {1'b0, sb[WIDTH-1:1]};
          carry_q <= bit_carry;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            cout  <= bit_carry;
            ovf   <= carry_q ^ bit_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_addsub
